// File: rtl/apb_master_arb_pkg.sv
// Shared types and constants for the two-requester APB master.
package apb_master_arb_pkg;

    localparam int STB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_e;

endpackage

// File: rtl/apb_master_arb_if.sv
// APB request/response bundle between the master and the address decoder.
interface apb_master_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]                     paddr;
    logic [DATA_WIDTH-1:0]                     pdata;
    logic                                      pwrite;
    logic [apb_master_arb_pkg::STB_W-1:0]      pstb;
    logic                                      psel;
    logic                                      penable;
    logic [DATA_WIDTH-1:0]                     prdata;
    logic                                      pready;
    logic                                      perr;

    modport master (
        output paddr, pdata, pwrite, pstb, psel, penable,
        input  prdata, pready, perr
    );

    modport slave (
        input  paddr, pdata, pwrite, pstb, psel, penable,
        output prdata, pready, perr
    );
endinterface

// File: rtl/apb_master_arb_rr_arb2.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the one not granted last.
module apb_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        grant = 1'b0;
        valid = |req;
        unique case (req)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end
endmodule

// File: rtl/apb_master_arb.sv
// Shares one APB bus between instruction fetch (m0) and load/store (m1) with round-robin
// arbitration, SETUP/ACCESS sequencing, registered completion and a hung-slave timeout.
module apb_master_arb
    import apb_master_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,

    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_write,
    input  logic [STB_W-1:0]      m0_stb,
    output logic                  m0_done,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_write,
    input  logic [STB_W-1:0]      m1_stb,
    output logic                  m1_done,
    output logic                  m1_err,

    output logic [DATA_WIDTH-1:0] rdata,

    apb_master_arb_if.master      apb
);

    // Width 1 when the timeout is disabled keeps the counter declaration legal.
    localparam int                  TIMER_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TIMER_W-1:0]  TIMER_MAX  = '1;

    state_e                 state_q;
    logic                   last_grant_q;
    logic                   gnt_q;
    logic [ADDR_WIDTH-1:0]  paddr_q;
    logic [DATA_WIDTH-1:0]  pdata_q;
    logic                   pwrite_q;
    logic [STB_W-1:0]       pstb_q;
    logic                   psel_q;
    logic                   penable_q;
    logic [TIMER_W-1:0]     timer_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   m0_done_q, m1_done_q, m0_err_q, m1_err_q;

    logic                   arb_grant;
    logic                   arb_valid;
    logic                   timeout_hit;
    logic                   acc_err;

    apb_rr_arb2 u_arb (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    assign timeout_hit = (TIMEOUT != 0) && !apb.pready && (timer_q == TIMER_LAST);
    assign acc_err     = apb.pready ? apb.perr : 1'b1;

    // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            paddr_q      <= '0;
            pdata_q      <= '0;
            pwrite_q     <= 1'b0;
            pstb_q       <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            timer_q      <= '0;
            rdata_q      <= '0;
            m0_done_q    <= 1'b0;
            m1_done_q    <= 1'b0;
            m0_err_q     <= 1'b0;
            m1_err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        gnt_q        <= arb_grant;
                        last_grant_q <= arb_grant;
                        paddr_q      <= arb_grant ? m1_addr  : m0_addr;
                        pdata_q      <= arb_grant ? m1_wdata : m0_wdata;
                        pwrite_q     <= arb_grant ? m1_write : m0_write;
                        // Strobes only mean something on writes.
                        if (arb_grant ? m1_write : m0_write)
                            pstb_q <= arb_grant ? m1_stb : m0_stb;
                        else
                            pstb_q <= '0;
                        psel_q       <= 1'b1;
                        state_q      <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    timer_q   <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (timer_q != TIMER_MAX)
                        timer_q <= timer_q + 1'b1;
                    if (apb.pready || timeout_hit) begin
                        rdata_q   <= (apb.pready && !pwrite_q) ? apb.prdata : '0;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        m0_done_q <= ~gnt_q;
                        m1_done_q <= gnt_q;
                        m0_err_q  <= ~gnt_q & acc_err;
                        m1_err_q  <= gnt_q & acc_err;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    m0_done_q <= 1'b0;
                    m1_done_q <= 1'b0;
                    m0_err_q  <= 1'b0;
                    m1_err_q  <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign apb.paddr   = paddr_q;
    assign apb.pdata   = pdata_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pstb    = pstb_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;

    assign rdata   = rdata_q;
    assign m0_done = m0_done_q;
    assign m1_done = m1_done_q;
    assign m0_err  = m0_err_q;
    assign m1_err  = m1_err_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: directed vector table, hand-written arbitration/reset sequences
// and a randomized run against a transaction-level reference model.
module tb_apb_master_arb;
    import apb_master_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int NEVER = 1000;

    logic pclk = 1'b0;
    logic presetn;

    logic          req_v   [2];
    logic [AW-1:0] addr_v  [2];
    logic [DW-1:0] wdata_v [2];
    logic          write_v [2];
    logic [3:0]    stb_v   [2];
    logic [1:0]    done_b;
    logic [1:0]    err_b;
    logic [DW-1:0] rdata;

    apb_master_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    apb_master_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .pclk     (pclk),
        .presetn  (presetn),
        .m0_req   (req_v[0]),
        .m0_addr  (addr_v[0]),
        .m0_wdata (wdata_v[0]),
        .m0_write (write_v[0]),
        .m0_stb   (stb_v[0]),
        .m0_done  (done_b[0]),
        .m0_err   (err_b[0]),
        .m1_req   (req_v[1]),
        .m1_addr  (addr_v[1]),
        .m1_wdata (wdata_v[1]),
        .m1_write (write_v[1]),
        .m1_stb   (stb_v[1]),
        .m1_done  (done_b[1]),
        .m1_err   (err_b[1]),
        .rdata    (rdata),
        .apb      (apb)
    );

    always #5 pclk = ~pclk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Behavioural slave: pready after sl_waits wait states, prdata/perr as configured.
    int            sl_waits;
    logic [DW-1:0] sl_prdata;
    logic          sl_perr;
    int            sl_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
        cyc++;
        if (apb.psel && apb.penable) begin
            apb.pready = (sl_cnt == sl_waits);
            apb.prdata = apb.pready ? sl_prdata : '0;
            apb.perr   = sl_perr;
            sl_cnt++;
        end else begin
            apb.pready = 1'b0;
            apb.prdata = '0;
            apb.perr   = 1'b0;
            sl_cnt     = 0;
        end
    endtask

    task automatic do_reset();
        presetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0; write_v[i] = 1'b0; stb_v[i] = '0;
        end
        step(); step(); step();
        presetn = 1'b1;
    endtask

    task automatic new_ops(input int m);
        addr_v[m]  = $urandom & 32'hFFFF_FFFC;
        wdata_v[m] = $urandom;
        write_v[m] = 1'($urandom_range(0, 1));
        stb_v[m]   = 4'($urandom_range(0, 15));
    endtask

    typedef struct {
        logic          m;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic          write;
        logic [3:0]    stb;
        int            waits;
        logic [31:0]   prdata;
        logic          perr;
        int            exp_lat;
        logic [31:0]   exp_rdata;
        logic          exp_err;
        logic [3:0]    exp_pstb;
        int            exp_psel;
    } vec_t;

    typedef struct {
        logic        m;
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    localparam int NV = 7;
    vec_t vt [NV];
    vec_t v;

    exp_t expq [$];
    exp_t e;
    int   rem [2];
    int   gap [2];
    int   free_at;
    logic last_g;
    logic [31:0] g_addr, g_wdata;
    logic g_write;
    logic [3:0] g_stb;

    int   t0, lat, psel_n, n_done;
    logic got, stable;
    logic [1:0] who, er;
    logic [DW-1:0] rd;
    logic [1:0] seq_who [4];
    int   seq_when [4];

    initial begin
        //          m  addr          wdata         wr stb    waits  prdata        perr lat rdata         err pstb  psel
        vt[0] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 1'b0, 4'hF, 0,     32'hDEAD_BEEF, 1'b0, 3,  32'hDEAD_BEEF, 1'b0, 4'h0, 2};
        vt[1] = '{1'b1, 32'h8000_0004, 32'h1234_5678, 1'b1, 4'h3, 2,     32'hAAAA_5555, 1'b0, 5,  32'h0000_0000, 1'b0, 4'h3, 4};
        vt[2] = '{1'b0, 32'h1000_0000, 32'h0000_0000, 1'b0, 4'h0, NEVER, 32'h1111_1111, 1'b0, 18, 32'h0000_0000, 1'b1, 4'h0, 17};
        vt[3] = '{1'b0, 32'h2000_0000, 32'h0000_0000, 1'b0, 4'h0, NEVER, 32'h2222_2222, 1'b1, 18, 32'h0000_0000, 1'b1, 4'h0, 17};
        vt[4] = '{1'b1, 32'h2000_0000, 32'h0000_0000, 1'b0, 4'h0, 0,     32'h0BAD_0BAD, 1'b1, 3,  32'h0BAD_0BAD, 1'b1, 4'h0, 2};
        vt[5] = '{1'b1, 32'h8000_0010, 32'h0000_0000, 1'b0, 4'h0, 15,    32'h5A5A_0001, 1'b0, 18, 32'h5A5A_0001, 1'b0, 4'h0, 17};
        vt[6] = '{1'b0, 32'h8000_0020, 32'hCAFE_F00D, 1'b1, 4'hF, 3,     32'h3333_3333, 1'b1, 6,  32'h0000_0000, 1'b1, 4'hF, 5};

        sl_waits = 0; sl_prdata = '0; sl_perr = 1'b0; sl_cnt = 0;
        apb.pready = 1'b0; apb.prdata = '0; apb.perr = 1'b0;
        do_reset();

        // Reset state
        check("rst_psel_penable", {apb.psel, apb.penable}, 2'b00);
        check("rst_done_err", {done_b, err_b}, 4'b0000);
        check("rst_rdata", rdata, 0);
        check("rst_apb_req", {apb.paddr, apb.pdata, apb.pwrite, apb.pstb}, 0);

        // Directed vectors; operands are scrambled mid-transfer to show they are ignored.
        for (int i = 0; i < NV; i++) begin
            v = vt[i];
            sl_waits = v.waits; sl_prdata = v.prdata; sl_perr = v.perr;
            req_v[v.m] = 1'b1; addr_v[v.m] = v.addr; wdata_v[v.m] = v.wdata;
            write_v[v.m] = v.write; stb_v[v.m] = v.stb;
            t0 = cyc; psel_n = 0; stable = 1'b1; got = 1'b0; lat = 0; who = '0; er = '0; rd = '0;
            for (int k = 0; k < 40 && !got; k++) begin
                step();
                if (k == 0) begin
                    addr_v[v.m] = ~v.addr; wdata_v[v.m] = ~v.wdata; write_v[v.m] = ~v.write; stb_v[v.m] = ~v.stb;
                end
                if (apb.psel) begin
                    psel_n++;
                    if (apb.paddr !== v.addr || apb.pdata !== v.wdata || apb.pwrite !== v.write || apb.pstb !== v.exp_pstb)
                        stable = 1'b0;
                end
                if (done_b != 2'b00) begin
                    got = 1'b1; lat = cyc - t0; who = done_b; er = err_b; rd = rdata;
                    req_v[v.m] = 1'b0;
                end
            end
            req_v[v.m] = 1'b0;
            check($sformatf("v%0d_done_seen", i), got, 1);
            check($sformatf("v%0d_latency", i), lat, v.exp_lat);
            check($sformatf("v%0d_done_who", i), who, v.m ? 2'b10 : 2'b01);
            check($sformatf("v%0d_err", i), er, v.m ? {v.exp_err, 1'b0} : {1'b0, v.exp_err});
            check($sformatf("v%0d_rdata", i), rd, v.exp_rdata);
            check($sformatf("v%0d_psel_cycles", i), psel_n, v.exp_psel);
            check($sformatf("v%0d_operands_stable", i), stable, 1);
            step();
            check($sformatf("v%0d_done_pulse_width", i), done_b, 2'b00);
            check($sformatf("v%0d_rdata_hold", i), rdata, v.exp_rdata);
        end

        // Simultaneous held requests after reset alternate m0,m1,m0,m1 every 4 cycles.
        do_reset();
        sl_waits = 0; sl_perr = 1'b0; sl_prdata = 32'h0000_00A5;
        for (int m = 0; m < 2; m++) begin
            new_ops(m); req_v[m] = 1'b1;
        end
        t0 = cyc; n_done = 0;
        for (int k = 0; k < 40 && n_done < 4; k++) begin
            step();
            if (done_b != 2'b00) begin
                seq_who[n_done] = done_b; seq_when[n_done] = cyc - t0; n_done++;
            end
        end
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        check("rr_done_count", n_done, 4);
        for (int j = 0; j < 4 && j < n_done; j++) begin
            check($sformatf("rr_grant%0d", j), seq_who[j], (j % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("rr_when%0d", j), seq_when[j], 3 + 4 * j);
        end

        // Reset during ACCESS aborts the transfer; m0 wins the first tie afterwards.
        do_reset();
        sl_waits = NEVER;
        new_ops(1); req_v[1] = 1'b1;
        step(); step(); step();
        check("abort_in_access", {apb.psel, apb.penable}, 2'b11);
        presetn = 1'b0;
        step();
        check("abort_psel_penable", {apb.psel, apb.penable}, 2'b00);
        check("abort_no_done", done_b, 2'b00);
        presetn = 1'b1;
        sl_waits = 0;
        new_ops(0); req_v[0] = 1'b1;
        t0 = cyc; got = 1'b0; who = '0; lat = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            step();
            if (done_b != 2'b00) begin got = 1'b1; who = done_b; lat = cyc - t0; end
        end
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        check("post_reset_first_grant", who, 2'b01);
        check("post_reset_latency", lat, 3);

        // Randomized traffic against the transaction-level model.
        do_reset();
        free_at = cyc; last_g = 1'b1;
        for (int m = 0; m < 2; m++) begin
            rem[m] = 12; gap[m] = $urandom_range(0, 5);
        end
        for (int k = 0; k < 3000; k++) begin
            if (rem[0] == 0 && rem[1] == 0 && expq.size() == 0 && cyc >= free_at) break;
            step();
            if (done_b != 2'b00) begin
                if (expq.size() == 0) begin
                    check("rand_spurious_done", done_b, 2'b00);
                end else begin
                    e = expq.pop_front();
                    check("rand_done_who", done_b, e.m ? 2'b10 : 2'b01);
                    check("rand_done_cycle", cyc, e.cyc);
                    check("rand_rdata", rdata, e.rdata);
                    check("rand_err", err_b, e.m ? {e.err, 1'b0} : {1'b0, e.err});
                end
            end else if (expq.size() != 0 && expq[0].cyc < cyc) begin
                check("rand_missed_done", cyc, expq[0].cyc);
                void'(expq.pop_front());
            end
            if (apb.psel) begin
                check("rand_apb_addr_ctl", {apb.paddr, apb.pwrite, apb.pstb}, {g_addr, g_write, g_stb});
                check("rand_apb_wdata", apb.pdata, g_wdata);
            end
            for (int m = 0; m < 2; m++) begin
                if (done_b[m]) begin
                    rem[m]--;
                    if (rem[m] > 0 && $urandom_range(0, 1) == 1) begin
                        new_ops(m);
                    end else begin
                        req_v[m] = 1'b0; gap[m] = $urandom_range(0, 3);
                    end
                end else if (!req_v[m] && rem[m] > 0) begin
                    if (gap[m] == 0) begin
                        new_ops(m); req_v[m] = 1'b1;
                    end else begin
                        gap[m]--;
                    end
                end
            end
            // Bus free and someone asking: this cycle's requests are the ones sampled.
            if (cyc >= free_at && (req_v[0] || req_v[1])) begin
                int w, r;
                logic m;
                m = (req_v[0] && req_v[1]) ? ~last_g : req_v[1];
                last_g = m;
                r = $urandom_range(0, 9);
                w = (r < 5) ? 0 : (r < 8) ? $urandom_range(1, 3) : (r == 8) ? TO - 1 : NEVER;
                sl_waits = w; sl_prdata = $urandom; sl_perr = ($urandom_range(0, 3) == 0);
                g_addr = addr_v[m]; g_wdata = wdata_v[m]; g_write = write_v[m];
                g_stb = write_v[m] ? stb_v[m] : 4'h0;
                e.m = m;
                if (w >= TO) begin
                    e.cyc = cyc + 2 + TO; e.err = 1'b1; e.rdata = '0;
                end else begin
                    e.cyc = cyc + 3 + w; e.err = sl_perr; e.rdata = write_v[m] ? '0 : sl_prdata;
                end
                expq.push_back(e);
                free_at = e.cyc + 1;
            end
        end
        check("rand_all_retired", {16'(rem[0]), 16'(rem[1]), 16'(expq.size())}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
